// File: rtl/vram_arbiter.sv
// Purpose : single-port VRAM arbiter, display fetch (strict priority) vs Z80 CPU access.
// Latency : display read 3 cycles request->disp_valid; CPU write ack at issue+2, read ack at issue+3.
// Backpress: display is never stalled; the CPU is held off through cpu_wait until its access completes.
//
// Ports:
//   pixel_clock, reset                     clock and synchronous active-high reset
//   disp_rd_enable/disp_addr               one-cycle display fetch request
//   disp_data/disp_valid                   returned display byte and its strobe
//   cpu_req/cpu_we/cpu_addr/cpu_wdata      level CPU request, held until cpu_ack
//   cpu_rdata/cpu_ack/cpu_wait             CPU read data, completion strobe, Z80 WAIT
//   ram_en/ram_we/ram_addr/ram_wdata       registered synchronous-SRAM command
//   ram_rdata                              SRAM read data, one cycle after the command
module vram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              disp_rd_enable,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_PEND  = 2'd1,
        C_BUSY  = 2'd2,
        C_REARM = 2'd3
    } cstate_t;

    cstate_t state, state_nxt;

    // CPU request captured at acceptance
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              accept;
    logic              cpu_issue;
    logic              disp_issue;
    logic              iss_we;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;
    logic              ack_nxt;

    // Owner tag pipeline. Stage 0 lines up with the registered RAM command,
    // stage 1 with the cycle ram_rdata is valid. Writes never reach stage 1.
    logic t0_vld, t0_cpu, t0_wr;
    logic t1_vld, t1_cpu;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        cpu_issue  = 1'b0;
        disp_issue = disp_rd_enable;
        iss_we     = lat_we;
        iss_addr   = lat_addr;
        iss_wdata  = lat_wdata;
        // Writes complete as soon as the command is on the port; reads one cycle later.
        ack_nxt    = (t1_vld & t1_cpu) | (t0_vld & t0_cpu & t0_wr);

        case (state)
            C_IDLE: begin
                if (cpu_req) begin
                    accept    = 1'b1;
                    // The acceptance cycle can also be the issue cycle, so bypass the latch.
                    iss_we    = cpu_we;
                    iss_addr  = cpu_addr;
                    iss_wdata = cpu_wdata;
                    if (!disp_rd_enable) begin
                        cpu_issue = 1'b1;
                        state_nxt = C_BUSY;
                    end else begin
                        state_nxt = C_PEND;
                    end
                end
            end
            C_PEND: begin
                if (!disp_rd_enable) begin
                    cpu_issue = 1'b1;
                    state_nxt = C_BUSY;
                end
            end
            C_BUSY: begin
                // Enter C_REARM together with the ack so the ack cycle already
                // counts towards seeing cpu_req low.
                if (ack_nxt) begin
                    state_nxt = C_REARM;
                end
            end
            C_REARM: begin
                if (!cpu_req) begin
                    state_nxt = C_IDLE;
                end
            end
            default: state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state      <= C_IDLE;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            t0_vld     <= 1'b0;
            t0_cpu     <= 1'b0;
            t0_wr      <= 1'b0;
            t1_vld     <= 1'b0;
            t1_cpu     <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                lat_we    <= cpu_we;
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
            end

            ram_en <= disp_issue | cpu_issue;
            ram_we <= cpu_issue & iss_we;
            if (disp_issue) begin
                ram_addr <= disp_addr;
            end else if (cpu_issue) begin
                ram_addr <= iss_addr;
                if (iss_we) begin
                    ram_wdata <= iss_wdata;
                end
            end

            t0_vld <= disp_issue | cpu_issue;
            t0_cpu <= cpu_issue;
            t0_wr  <= cpu_issue & iss_we;
            t1_vld <= t0_vld & ~t0_wr;
            t1_cpu <= t0_cpu;

            disp_valid <= t1_vld & ~t1_cpu;
            if (t1_vld && !t1_cpu) begin
                disp_data <= ram_rdata;
            end

            cpu_ack <= ack_nxt;
            if (t1_vld && t1_cpu) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

    assign cpu_wait = cpu_req & (state != C_REARM) & ~cpu_ack;

endmodule
